pes_booth_seq: RTL and testbench

- Operand sequencer and result capture stage wrapped around the radix-2 Booth multiplier pes_r2_4bm.
- Accepts signed operand pairs over a valid/ready handshake and drives the multiplier's M, Q and load.
- Waits out the fixed iteration latency, samples the 2N-bit product P and presents it downstream over a valid/ready handshake.
- Removes the need for upstream logic to know multiplier timing.

---
 rtl/pes_booth_pkg.sv | 26 ++
 rtl/pes_booth_seq_cnt.sv | 32 +++
 rtl/pes_booth_seq.sv | 120 ++++++++++++
 tb/tb_pes_booth_seq.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/pes_booth_pkg.sv
// Shared types and defaults for the Booth multiplier operand sequencer.
// Holds the FSM state encoding and a generic product sign-extension helper.
package pes_booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        HOLD = 2'd3
    } state_e;

    localparam int DEF_N       = 4;
    localparam int DEF_MUL_LAT = 4;
    localparam int DEF_ACC_W   = 16;

    // Replicates bit from_w-1 of v into every bit above it; callers truncate to their width.
    function automatic logic [63:0] sign_extend(input logic [63:0] v, input int from_w);
        logic [63:0] r;
        r = v;
        for (int i = 0; i < 64; i++) begin
            if (i >= from_w) r[i] = v[6'(from_w - 1)];
        end
        return r;
    endfunction

endpackage

// File: rtl/pes_booth_seq_cnt.sv
// Latency down-counter: loads MUL_LAT, counts down while enabled, done at zero.
module pes_booth_seq_cnt #(
    parameter int MUL_LAT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic done
);

    localparam int CW = $clog2(MUL_LAT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = CW'(MUL_LAT);
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    assign done = (cnt_q == '0);

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/pes_booth_seq.sv
// Operand sequencer and result capture around the radix-2 Booth multiplier.
// Define PES_BSEQ_ACC_EN to turn the result register into a running accumulator.
module pes_booth_seq
    import pes_booth_pkg::*;
#(
    parameter int N       = DEF_N,
    parameter int MUL_LAT = DEF_MUL_LAT,
    parameter int ACC_W   = DEF_ACC_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_m,
    input  logic [N-1:0]     in_q,
    input  logic             acc_clr,
    output logic             mul_load,
    output logic             mul_reset,
    output logic [N-1:0]     mul_m,
    output logic [N-1:0]     mul_q,
    input  logic [2*N-1:0]   mul_p,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             busy
);

    state_e           state_q, state_d;
    logic             in_ready_q, in_ready_d;
    logic             mul_load_q, mul_load_d;
    logic             mul_reset_q, mul_reset_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;
    logic [N-1:0]     mul_m_q, mul_m_d;
    logic [N-1:0]     mul_q_q, mul_q_d;
    logic [ACC_W-1:0] res_q, res_d;
    logic [ACC_W-1:0] prod_ext;
    logic             cnt_done;
    logic             accept;
    logic             capture;

    // Counter is armed during LOAD so capture lands MUL_LAT edges after the multiplier samples load.
    pes_booth_seq_cnt #(.MUL_LAT(MUL_LAT)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .load  (state_q == LOAD),
        .en    (state_q == RUN),
        .done  (cnt_done)
    );

    assign accept   = (state_q == IDLE) && in_valid;
    assign capture  = (state_q == RUN) && cnt_done;
    assign prod_ext = ACC_W'(sign_extend(64'(mul_p), 2 * N));

`ifndef PES_BSEQ_ACC_EN
    logic unused_acc_clr;
    assign unused_acc_clr = acc_clr;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = LOAD;
            LOAD:    state_d = RUN;
            RUN:     if (cnt_done) state_d = HOLD;
            HOLD:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        in_ready_d  = (state_d == IDLE);
        mul_load_d  = (state_d == LOAD);
        out_valid_d = (state_d == HOLD);
        busy_d      = (state_d != IDLE);
        mul_reset_d = 1'b0;
        mul_m_d     = accept ? in_m : mul_m_q;
        mul_q_d     = accept ? in_q : mul_q_q;

`ifdef PES_BSEQ_ACC_EN
        // A clear on the capture edge restarts the sum from this product.
        res_d = acc_clr ? '0 : res_q;
        if (capture) res_d = res_d + prod_ext;
`else
        res_d = capture ? prod_ext : res_q;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            mul_load_q  <= 1'b0;
            mul_reset_q <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            mul_m_q     <= '0;
            mul_q_q     <= '0;
            res_q       <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            mul_load_q  <= mul_load_d;
            mul_reset_q <= mul_reset_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            mul_m_q     <= mul_m_d;
            mul_q_q     <= mul_q_d;
            res_q       <= res_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign mul_load  = mul_load_q;
    assign mul_reset = mul_reset_q;
    assign mul_m     = mul_m_q;
    assign mul_q     = mul_q_q;
    assign out_valid = out_valid_q;
    assign out_data  = res_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_pes_booth_seq.sv
// Directed bench for pes_booth_seq with a latency-accurate multiplier stand-in.
// Build with PES_BSEQ_ACC_EN defined to check the accumulating variant.
module tb_pes_booth_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_m = '0;
    logic [3:0]  in_q = '0;
    logic        acc_clr = 1'b0;
    logic        mul_load;
    logic        mul_reset;
    logic [3:0]  mul_m;
    logic [3:0]  mul_q;
    logic [7:0]  mul_p = 8'hA5;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;
    int mcnt = 0;
    int sidx = 0;
    logic stream_on = 1'b0;
    logic [3:0]  sm [4];
    logic [3:0]  sq [4];
    logic [15:0] sexp [4];

    pes_booth_seq dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_m      (in_m),
        .in_q      (in_q),
        .acc_clr   (acc_clr),
        .mul_load  (mul_load),
        .mul_reset (mul_reset),
        .mul_m     (mul_m),
        .mul_q     (mul_q),
        .mul_p     (mul_p),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] prod8(input logic [3:0] m, input logic [3:0] q);
        logic signed [7:0] a, b;
        a = {{4{m[3]}}, m};
        b = {{4{q[3]}}, q};
        return a * b;
    endfunction

    // Product is garbage until MUL_LAT edges after the edge that samples load.
    always @(posedge clk) begin
        if (mul_reset || mul_load) begin
            mcnt  <= 0;
            mul_p <= 8'hA5;
        end else if (mcnt < 4) begin
            mcnt <= mcnt + 1;
            if (mcnt == 3) mul_p <= prod8(mul_m, mul_q);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (stream_on && out_valid) begin
            if (sidx < 4) check("stream_data", 32'(out_data), 32'(sexp[sidx]));
            sidx++;
        end
    end

    task automatic do_op(input logic [3:0] m, input logic [3:0] q,
                         input logic [15:0] exp, input int hold);
        int n;
        in_m = m;
        in_q = q;
        in_valid = 1'b1;
        check("op_in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check("load_pulse", 32'(mul_load), 32'd1);
        check("mul_m", 32'(mul_m), 32'(m));
        check("mul_q", 32'(mul_q), 32'(q));
        check("busy_ready", 32'({busy, in_ready}), 32'b10);
        n = 0;
        while (!out_valid && n < 20) begin
            in_valid = n[0];
            in_m = ~m;
            in_q = ~q;
            out_ready = n[0];
            tick();
            n++;
            if (n == 1) check("load_low", 32'(mul_load), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        check("latency", 32'(n), 32'd6);
        check("mul_m_held", 32'({mul_m, mul_q}), 32'({m, q}));
        check("out_data", 32'(out_data), 32'(exp));
        for (int i = 0; i < hold; i++) begin
            in_valid = i[0];
            tick();
            check("hold", 32'({out_valid, in_ready, out_data}), 32'({2'b10, exp}));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("release", 32'({out_valid, in_ready, busy}), 32'b010);
    endtask

    initial begin
        int k;
        int guard;
        logic was_ready;

        sm[0] = 4'b0001; sq[0] = 4'b0001;
        sm[1] = 4'b1111; sq[1] = 4'b0111;
        sm[2] = 4'b0011; sq[2] = 4'b1100;
        sm[3] = 4'b1000; sq[3] = 4'b0111;
`ifdef PES_BSEQ_ACC_EN
        sexp[0] = 16'h0001; sexp[1] = 16'hFFFA; sexp[2] = 16'hFFEE; sexp[3] = 16'hFFB6;
`else
        sexp[0] = 16'h0001; sexp[1] = 16'hFFF9; sexp[2] = 16'hFFF4; sexp[3] = 16'hFFC8;
`endif

        reset = 1'b1;
        tick();
        tick();
        check("rst_ready_load", 32'({in_ready, mul_load, mul_reset}), 32'b101);
        check("rst_mq", 32'({mul_m, mul_q}), 32'd0);
        check("rst_out", 32'({out_valid, busy, out_data}), 32'd0);
        reset = 1'b0;
        tick();
        check("mul_reset_drop", 32'(mul_reset), 32'd0);

`ifdef PES_BSEQ_ACC_EN
        do_op(4'b1010, 4'b1011, 16'h001E, 5);
        do_op(4'b0111, 4'b1000, 16'hFFE6, 0);
        do_op(4'b1000, 4'b1000, 16'h0026, 0);
`else
        do_op(4'b1010, 4'b1011, 16'h001E, 5);
        do_op(4'b0111, 4'b1000, 16'hFFC8, 0);
        do_op(4'b1000, 4'b1000, 16'h0040, 0);
`endif

        in_m = 4'b0101;
        in_q = 4'b0011;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_run_state", 32'({out_valid, in_ready, busy, mul_reset}), 32'b0101);
        check("rst_run_data", 32'(out_data), 32'd0);
        for (int i = 0; i < 8; i++) tick();
        check("rst_run_no_valid", 32'({out_valid, mul_reset, in_ready}), 32'b001);

        acc_clr = 1'b1;
        tick();
        acc_clr = 1'b0;
        do_op(4'b1010, 4'b1011, 16'h001E, 1);

        acc_clr = 1'b1;
        tick();
        acc_clr = 1'b0;
        stream_on = 1'b1;
        out_ready = 1'b1;
        k = 0;
        guard = 0;
        in_m = sm[0];
        in_q = sq[0];
        in_valid = 1'b1;
        while (k < 4 && guard < 200) begin
            was_ready = in_ready;
            tick();
            guard++;
            if (was_ready) begin
                k++;
                if (k < 4) begin
                    in_m = sm[k];
                    in_q = sq[k];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid = 1'b0;
        check("stream_accepts", 32'(k), 32'd4);
        guard = 0;
        while (sidx < 4 && guard < 50) begin
            tick();
            guard++;
        end
        for (int i = 0; i < 10; i++) tick();
        stream_on = 1'b0;
        out_ready = 1'b0;
        check("stream_count", 32'(sidx), 32'd4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
